conv_sched: RTL and testbench

Layer sequencer for the convolution datapath. It accepts one input stream: 9 kernel words followed by a row-major image. It loads the kernel register file and the 3-row line buffer, then runs the convolution engine once per output row. Between windows it advances the line buffer by the configured stride. It sits between the input DMA stream and the kernel_reg / LineBuffer / convolve cluster.

---
 rtl/conv_sched.sv | 213 +++++++++++++++++++++
 tb/tb_conv_sched.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_sched.sv
// conv_sched: layer sequencer for the convolution datapath.
// Consumes one stream (9 kernel words, then the image row-major), fills the
// kernel registers and the 3-row line buffer, launches one convolve pass per
// output row and slides the line buffer down by the stride between passes.
module conv_sched #(
    parameter int BIT_DEPTH = 8,
    parameter int COLS      = 28,
    parameter int IMG_ROWS  = 28
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cfg_start,
    input  logic [1:0]           cfg_stride,
    input  logic                 cfg_pool_en,
    input  logic                 in_valid,
    input  logic [BIT_DEPTH-1:0] in_data,
    output logic                 in_ready,
    output logic                 kr_wr_en,
    output logic [3:0]           kr_addr,
    output logic [BIT_DEPTH-1:0] kr_data,
    output logic                 lb_wr_en,
    output logic [1:0]           lb_row,
    output logic [4:0]           lb_col,
    output logic [BIT_DEPTH-1:0] lb_data,
    output logic                 lb_row_shift,
    output logic                 conv_start,
    output logic [1:0]           conv_stride,
    output logic                 conv_pool_en,
    output logic [9:0]           conv_dest_base,
    input  logic                 conv_done,
    output logic                 busy,
    output logic                 layer_done
);

    // Output columns per row for each legal stride.
    localparam int OC1 = (COLS - 3) / 1 + 1;
    localparam int OC2 = (COLS - 3) / 2 + 1;
    localparam int OC3 = (COLS - 3) / 3 + 1;
    // top_row must hold IMG_ROWS plus headroom for the +stride step.
    localparam int TRW = $clog2(IMG_ROWS + 4) + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_K,
        S_LOAD_ROWS,
        S_RUN,
        S_WAIT,
        S_SHIFT,
        S_LOAD_ONE,
        S_DONE
    } state_t;

    state_t         state_q, state_d;
    logic [1:0]     stride_q, stride_d;
    logic           pool_q, pool_d;
    logic [3:0]     kcnt_q, kcnt_d;
    logic [1:0]     row_q, row_d;
    logic [4:0]     col_q, col_d;
    logic [TRW-1:0] top_q, top_d;
    logic [1:0]     adv_q, adv_d;
    logic [9:0]     base_q, base_d;

    logic [9:0]     out_cols;
    logic [TRW-1:0] top_next;

    // Stride-dependent row pitch of the result buffer and the next window top.
    always_comb begin
        case (stride_q)
            2'd2:    out_cols = 10'(OC2);
            2'd3:    out_cols = 10'(OC3);
            default: out_cols = 10'(OC1);
        endcase
        top_next = top_q + TRW'(stride_q);
    end

    // Next-state, counter updates and per-cycle strobes.
    always_comb begin
        state_d      = state_q;
        stride_d     = stride_q;
        pool_d       = pool_q;
        kcnt_d       = kcnt_q;
        row_d        = row_q;
        col_d        = col_q;
        top_d        = top_q;
        adv_d        = adv_q;
        base_d       = base_q;
        in_ready     = 1'b0;
        kr_wr_en     = 1'b0;
        lb_wr_en     = 1'b0;
        lb_row_shift = 1'b0;
        conv_start   = 1'b0;
        layer_done   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (cfg_start) begin
                    stride_d = (cfg_stride == 2'd0) ? 2'd1 : cfg_stride;
                    pool_d   = cfg_pool_en;
                    kcnt_d   = '0;
                    row_d    = '0;
                    col_d    = '0;
                    top_d    = '0;
                    adv_d    = '0;
                    base_d   = '0;
                    state_d  = S_LOAD_K;
                end
            end
            S_LOAD_K: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    kr_wr_en = 1'b1;
                    if (kcnt_q == 4'd8) begin
                        kcnt_d  = '0;
                        state_d = S_LOAD_ROWS;
                    end else begin
                        kcnt_d = kcnt_q + 4'd1;
                    end
                end
            end
            S_LOAD_ROWS: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    lb_wr_en = 1'b1;
                    if (col_q == 5'(COLS - 1)) begin
                        col_d = '0;
                        if (row_q == 2'd2) begin
                            row_d   = '0;
                            state_d = S_RUN;
                        end else begin
                            row_d = row_q + 2'd1;
                        end
                    end else begin
                        col_d = col_q + 5'd1;
                    end
                end
            end
            S_RUN: begin
                conv_start = 1'b1;
                state_d    = S_WAIT;
            end
            S_WAIT: begin
                if (conv_done) begin
                    base_d = base_q + out_cols;
                    top_d  = top_next;
                    if (int'(top_next) + 3 > IMG_ROWS) begin
                        state_d = S_DONE;
                    end else begin
                        adv_d   = stride_q;
                        state_d = S_SHIFT;
                    end
                end
            end
            S_SHIFT: begin
                lb_row_shift = 1'b1;
                state_d      = S_LOAD_ONE;
            end
            S_LOAD_ONE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    lb_wr_en = 1'b1;
                    if (col_q == 5'(COLS - 1)) begin
                        col_d   = '0;
                        adv_d   = adv_q - 2'd1;
                        state_d = (adv_q == 2'd1) ? S_RUN : S_SHIFT;
                    end else begin
                        col_d = col_q + 5'd1;
                    end
                end
            end
            S_DONE: begin
                layer_done = 1'b1;
                state_d    = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and counter registers; reset returns to an idle, stride-1 layer.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            stride_q <= 2'd1;
            pool_q   <= 1'b0;
            kcnt_q   <= '0;
            row_q    <= '0;
            col_q    <= '0;
            top_q    <= '0;
            adv_q    <= '0;
            base_q   <= '0;
        end else begin
            state_q  <= state_d;
            stride_q <= stride_d;
            pool_q   <= pool_d;
            kcnt_q   <= kcnt_d;
            row_q    <= row_d;
            col_q    <= col_d;
            top_q    <= top_d;
            adv_q    <= adv_d;
            base_q   <= base_d;
        end
    end

    assign kr_addr        = kcnt_q;
    assign kr_data        = in_data;
    assign lb_row         = (state_q == S_LOAD_ONE) ? 2'd2 : row_q;
    assign lb_col         = col_q;
    assign lb_data        = in_data;
    assign conv_stride    = stride_q;
    assign conv_pool_en   = pool_q;
    assign conv_dest_base = base_q;
    assign busy           = (state_q != S_IDLE);

endmodule

// File: tb/tb_conv_sched.sv
// tb_conv_sched: scoreboard bench for conv_sched. Expected write events and
// window base addresses are queued as stimulus is driven and popped as the
// sequencer produces strobes; a responder answers conv_start with conv_done.
module tb_conv_sched;

    localparam int BD   = 8;
    localparam int COLS = 28;
    localparam int ROWS = 28;

    logic          clk = 1'b0;
    logic          rst;
    logic          cfg_start;
    logic [1:0]    cfg_stride;
    logic          cfg_pool_en;
    logic          in_valid;
    logic [BD-1:0] in_data;
    logic          in_ready;
    logic          kr_wr_en;
    logic [3:0]    kr_addr;
    logic [BD-1:0] kr_data;
    logic          lb_wr_en;
    logic [1:0]    lb_row;
    logic [4:0]    lb_col;
    logic [BD-1:0] lb_data;
    logic          lb_row_shift;
    logic          conv_start;
    logic [1:0]    conv_stride;
    logic          conv_pool_en;
    logic [9:0]    conv_dest_base;
    logic          conv_done;
    logic          busy;
    logic          layer_done;

    logic start_main, start_poke, done_resp, done_main;
    assign cfg_start = start_main | start_poke;
    assign conv_done = done_resp | done_main;

    conv_sched #(.BIT_DEPTH(BD), .COLS(COLS), .IMG_ROWS(ROWS)) dut (
        .clk(clk), .rst(rst),
        .cfg_start(cfg_start), .cfg_stride(cfg_stride), .cfg_pool_en(cfg_pool_en),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .kr_wr_en(kr_wr_en), .kr_addr(kr_addr), .kr_data(kr_data),
        .lb_wr_en(lb_wr_en), .lb_row(lb_row), .lb_col(lb_col), .lb_data(lb_data),
        .lb_row_shift(lb_row_shift), .conv_start(conv_start),
        .conv_stride(conv_stride), .conv_pool_en(conv_pool_en),
        .conv_dest_base(conv_dest_base), .conv_done(conv_done),
        .busy(busy), .layer_done(layer_done)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    logic [31:0] wr_q[$];
    logic [9:0]  conv_q[$];
    int cyc = 0, conv_cnt = 0, shift_cnt = 0, done_cnt = 0;
    int shifts_since = 0, writes_since = 0, k0cyc = 0;
    int exp_s = 1;
    logic exp_pool = 1'b0;
    logic no_stall = 1'b1;
    logic poke_en = 1'b0;
    logic chk_ready_next = 1'b0, chk_after_done = 1'b0, chk_idle_next = 1'b0;

    // Count one comparison and report it if the observed value differs.
    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [7:0] wordVal(input int i);
        if (i < 9) return 8'(i + 1);
        return 8'((i * 37 + 11) % 256);
    endfunction

    // Expected write event for stream word i: {kind, row, col/addr, data}.
    function automatic logic [31:0] expWord(input int i);
        int j, r, c;
        if (i < 9) return {16'd0, 1'b1, 2'b00, 5'(i), wordVal(i)};
        j = i - 9;
        r = j / COLS;
        c = j % COLS;
        return {16'd0, 1'b0, (r < 3) ? 2'(r) : 2'd2, 5'(c), wordVal(i)};
    endfunction

    task automatic checkResetState(input string tag);
        checkOutput(tag,
            32'({in_ready, kr_wr_en, kr_addr, lb_wr_en, lb_row, lb_col, lb_row_shift,
                 conv_start, conv_stride, conv_pool_en, conv_dest_base, busy, layer_done}),
            32'({1'b0, 1'b0, 4'd0, 1'b0, 2'd0, 5'd0, 1'b0,
                 1'b0, 2'd1, 1'b0, 10'd0, 1'b0, 1'b0}));
    endtask

    // Monitor: pops the scoreboard on every strobe and checks handshake timing.
    initial begin
        logic [31:0] act;
        logic [31:0] e;
        logic [9:0]  eb;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst || !busy) begin
                shifts_since = 0;
                writes_since = 0;
            end
            if (rst) begin
                if (chk_ready_next) begin
                    chk_ready_next = 1'b0;
                    checkOutput("ready_into_rows", 32'({in_ready, lb_wr_en}), 32'd3);
                end
                if (chk_after_done) begin
                    chk_after_done = 1'b0;
                    checkOutput("resp_after_done", 32'(lb_row_shift | layer_done), 32'd1);
                end
                if (chk_idle_next) begin
                    chk_idle_next = 1'b0;
                    checkOutput("busy_after_layer", 32'({busy, in_ready}), 32'd0);
                end
                if (kr_wr_en || lb_wr_en) begin
                    checkOutput("strobe_valid", 32'({kr_wr_en & lb_wr_en, in_valid}), 32'd1);
                    act = kr_wr_en ? {16'd0, 1'b1, 2'b00, 1'b0, kr_addr, kr_data}
                                   : {16'd0, 1'b0, lb_row, lb_col, lb_data};
                    if (wr_q.size() == 0) begin
                        checkOutput("wr_unexpected", act, 32'hFFFF_FFFF);
                    end else begin
                        e = wr_q.pop_front();
                        checkOutput("wr_event", act, e);
                    end
                    if (kr_wr_en && kr_addr == 4'd0) k0cyc = cyc;
                    if (kr_wr_en && kr_addr == 4'd8 && no_stall) begin
                        checkOutput("k_consecutive", 32'(cyc - k0cyc), 32'd8);
                        chk_ready_next = 1'b1;
                    end
                    if (lb_wr_en && shifts_since > 0) begin
                        writes_since++;
                        checkOutput("refill_row", 32'(lb_row), 32'd2);
                    end
                end
                if (lb_row_shift) begin
                    shift_cnt++;
                    shifts_since++;
                end
                if (conv_start) begin
                    conv_cnt++;
                    if (conv_q.size() == 0) begin
                        checkOutput("conv_unexpected", 32'(conv_dest_base), 32'hFFFF_FFFF);
                    end else begin
                        eb = conv_q.pop_front();
                        checkOutput("dest_base", 32'(conv_dest_base), 32'(eb));
                        checkOutput("conv_stride", 32'(conv_stride), 32'(exp_s));
                        checkOutput("conv_pool_en", 32'(conv_pool_en), 32'(exp_pool));
                        if (eb != 10'd0)
                            checkOutput("refill_amount", {16'(shifts_since), 16'(writes_since)},
                                        {16'(exp_s), 16'(COLS * exp_s)});
                    end
                    shifts_since = 0;
                    writes_since = 0;
                end
                if (conv_done && busy) chk_after_done = 1'b1;
                if (layer_done) begin
                    done_cnt++;
                    chk_idle_next = 1'b1;
                end
            end
        end
    end

    // Convolve stand-in: conv_done 5 cycles after conv_start, optionally with
    // stray cfg_start pulses during WAIT (alone, then together with conv_done).
    initial begin
        done_resp  = 1'b0;
        start_poke = 1'b0;
        forever begin
            @(negedge clk);
            if (rst && conv_start) begin
                repeat (3) @(posedge clk);
                #1 start_poke = poke_en;
                @(posedge clk);
                #1 start_poke = 1'b0;
                @(posedge clk);
                #1 done_resp = 1'b1;
                start_poke = poke_en;
                @(posedge clk);
                #1 done_resp = 1'b0;
                start_poke = 1'b0;
            end
        end
    end

    // Run one layer: start, stream kernel and image, then check the totals.
    // A nonzero abort_win resets mid-refill before window abort_win.
    task automatic applyStimulus(input int stride, input logic pool, input logic stall,
                                 input logic poke, input int abort_win);
        int s, nw, oc, nwords, c0, sh0, d0, i, pushed, budget;
        logic xfer;
        s      = (stride == 0) ? 1 : stride;
        nw     = (ROWS - 3) / s + 1;
        oc     = (COLS - 3) / s + 1;
        nwords = 9 + (3 + (nw - 1) * s) * COLS;
        c0 = conv_cnt; sh0 = shift_cnt; d0 = done_cnt;
        exp_s = s; exp_pool = pool; no_stall = !stall; poke_en = poke;
        for (int k = 0; k < nw; k++) conv_q.push_back(10'(k * oc));

        @(posedge clk);
        #1 start_main = 1'b1;
        cfg_stride  = 2'(stride);
        cfg_pool_en = pool;
        @(posedge clk);
        #1 start_main = 1'b0;
        cfg_stride  = 2'd3;
        cfg_pool_en = !pool;
        i = 0;
        wr_q.push_back(expWord(0));
        pushed = 1;
        in_data  = wordVal(0);
        in_valid = stall ? 1'($urandom_range(0, 1)) : 1'b1;
        @(negedge clk);
        checkOutput("busy_after_start", 32'({busy, in_ready}), 32'd3);

        budget = 0;
        while (i < nwords) begin
            xfer = in_valid && in_ready;
            if (abort_win > 0 && conv_cnt - c0 == abort_win - 1 && shifts_since == 1
                && writes_since >= 10) begin
                rst = 1'b0;
                #1;
                checkResetState("abort_outputs");
                in_valid = 1'b0;
                wr_q.delete();
                conv_q.delete();
                poke_en = 1'b0;
                repeat (2) @(posedge clk);
                #1 rst = 1'b1;
                return;
            end
            @(posedge clk);
            #1;
            if (xfer) i++;
            budget++;
            if (budget > 20000) begin
                checkOutput("stream_timeout", 32'(i), 32'(nwords));
                break;
            end
            if (i < nwords) begin
                if (pushed == i) begin
                    wr_q.push_back(expWord(i));
                    pushed++;
                end
                in_data  = wordVal(i);
                in_valid = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
        end
        in_valid = 1'b0;

        budget = 0;
        while (done_cnt == d0 && budget < 500) begin
            @(negedge clk);
            budget++;
        end
        repeat (3) @(negedge clk);
        checkOutput("layer_done_once", 32'(done_cnt - d0), 32'd1);
        checkOutput("conv_count", 32'(conv_cnt - c0), 32'(nw));
        checkOutput("shift_count", 32'(shift_cnt - sh0), 32'((nw - 1) * s));
        checkOutput("wr_queue_left", 32'(wr_q.size()), 32'd0);
        checkOutput("conv_queue_left", 32'(conv_q.size()), 32'd0);
        checkOutput("idle_after_layer", 32'({busy, in_ready}), 32'd0);
        poke_en = 1'b0;
    endtask

    initial begin
        rst         = 1'b0;
        start_main  = 1'b0;
        done_main   = 1'b0;
        cfg_stride  = 2'd2;
        cfg_pool_en = 1'b0;
        in_valid    = 1'b0;
        in_data     = '0;
        repeat (3) @(negedge clk);
        checkResetState("reset_hold");

        @(posedge clk);
        #1 rst = 1'b1;
        repeat (4) @(negedge clk);
        checkOutput("idle_no_start", 32'({busy, in_ready}), 32'd0);

        @(posedge clk);
        #1 done_main = 1'b1;
        @(posedge clk);
        #1 done_main = 1'b0;
        @(negedge clk);
        checkOutput("spurious_done", 32'({busy, in_ready, lb_row_shift, layer_done, conv_start}), 32'd0);

        $display("[TB] stride 1 layer with kernel load and stray starts in WAIT");
        applyStimulus(1, 1'b0, 1'b0, 1'b1, 0);
        $display("[TB] stride 2 layer with pooling");
        applyStimulus(2, 1'b1, 1'b0, 1'b0, 0);
        $display("[TB] stride 0 layer with random stalls");
        applyStimulus(0, 1'b0, 1'b1, 1'b0, 0);
        $display("[TB] reset during refill before window 4");
        applyStimulus(1, 1'b0, 1'b0, 1'b0, 4);
        checkResetState("after_abort");
        $display("[TB] clean layer after abort");
        applyStimulus(1, 1'b0, 1'b0, 1'b1, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
